mul_seq_ctrl: RTL and testbench

MUL_SEQ_CTRL -- requirements
Module: mul_seq_ctrl

---
 rtl/mul_pkg.sv | 18 +
 rtl/mul_seq_ctrl_top.sv | 57 +++++
 rtl/mul_seq_ctrl.sv | 114 +++++++++++
 tb/tb_mul_seq_ctrl.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared definitions for the sequential multiply controller: FSM encoding and
// the post-reset holdoff length that masks a stale core done.
package mul_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StWait,
        StResp,
        StDrain
    } state_e;

    // A core left running across reset finishes within n+1 cycles; 2n+2 is a safe margin.
    function automatic int unsigned holdoff_cycles(input int unsigned n);
        return 2 * n + 2;
    endfunction

endpackage

// File: rtl/mul_seq_ctrl_top.sv
// Radix-2 Booth multiplier core: pulse start with operands, done pulses for one
// cycle N+1 cycles later with the signed 2N-bit product on data_out.
module top #(
    parameter int unsigned N = 4
) (
    input  logic           clk,
    input  logic           start,
    input  logic [N-1:0]   data_M,
    input  logic [N-1:0]   data_Q,
    output logic [2*N-1:0] data_out,
    output logic           done
);

    localparam int unsigned CntW = $clog2(N + 1);

    // Accumulator carries one guard bit so subtracting -2^(N-1) cannot overflow.
    logic [N:0]      acc_q;
    logic [N:0]      m_q;
    logic [N-1:0]    q_q;
    logic            q_m1_q;
    logic [CntW-1:0] cnt_q;
    logic            run_q;
    logic            done_q;
    logic [N:0]      sum;

    always_comb begin
        sum = acc_q;
        case ({q_q[0], q_m1_q})
            2'b01:   sum = acc_q + m_q;
            2'b10:   sum = acc_q - m_q;
            default: sum = acc_q;
        endcase
    end

    always_ff @(posedge clk) begin
        done_q <= 1'b0;
        if (start) begin
            acc_q  <= '0;
            m_q    <= {data_M[N-1], data_M};
            q_q    <= data_Q;
            q_m1_q <= 1'b0;
            cnt_q  <= CntW'(N);
            run_q  <= 1'b1;
        end else if (run_q) begin
            {acc_q, q_q, q_m1_q} <= {sum[N], sum, q_q};
            cnt_q                <= cnt_q - CntW'(1);
            if (cnt_q == CntW'(1)) begin
                run_q  <= 1'b0;
                done_q <= 1'b1;
            end
        end
    end

    assign data_out = {acc_q[N-1:0], q_q};
    assign done     = done_q;

endmodule

// File: rtl/mul_seq_ctrl.sv
// Valid/ready front end for the Booth core with a single-entry product cache,
// flush/drain handling and a post-reset holdoff.
module mul_seq_ctrl
    import mul_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         op_high,
    input  logic [N-1:0] rs1,
    input  logic [N-1:0] rs2,
    input  logic         flush,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] result,
    output logic         busy
);

    localparam int unsigned Holdoff = holdoff_cycles(N);
    localparam int unsigned HoldW   = $clog2(Holdoff + 1);

    state_e           state_q, state_d;
    logic [N-1:0]     rs1_q, rs2_q;
    logic             op_high_q;
    logic [N-1:0]     c_rs1_q, c_rs2_q;
    logic [2*N-1:0]   c_prod_q;
    logic             c_valid_q;
    logic [HoldW-1:0] holdoff_q;

    logic             core_start;
    logic             core_done;
    logic [2*N-1:0]   core_prod;
    logic             accept;
    logic             hit;
    logic             capture;

    top #(
        .N(N)
    ) u_core (
        .clk     (clk),
        .start   (core_start),
        .data_M  (rs1_q),
        .data_Q  (rs2_q),
        .data_out(core_prod),
        .done    (core_done)
    );

    assign in_ready   = (state_q == StIdle) && !flush && (holdoff_q == '0);
    assign accept     = in_valid && in_ready;
    assign hit        = c_valid_q && (rs1 == c_rs1_q) && (rs2 == c_rs2_q);
    assign core_start = (state_q == StStart);
    assign busy       = (state_q != StIdle);
    assign out_valid  = (state_q == StResp) && !flush;
    assign result     = (state_q == StResp) ? (op_high_q ? c_prod_q[2*N-1:N] : c_prod_q[N-1:0])
                                            : '0;

    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (accept) state_d = hit ? StResp : StStart;
            end
            StStart: begin
                state_d = flush ? StDrain : StWait;
            end
            StWait: begin
                // A flush landing on done still discards the product.
                if (core_done) begin
                    state_d = flush ? StIdle : StResp;
                    capture = !flush;
                end else if (flush) begin
                    state_d = StDrain;
                end
            end
            StResp: begin
                if (flush || out_ready) state_d = StIdle;
            end
            StDrain: begin
                if (core_done) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            c_valid_q <= 1'b0;
            holdoff_q <= HoldW'(Holdoff);
            rs1_q     <= '0;
            rs2_q     <= '0;
            op_high_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (holdoff_q != '0) holdoff_q <= holdoff_q - HoldW'(1);
            if (accept) begin
                rs1_q     <= rs1;
                rs2_q     <= rs2;
                op_high_q <= op_high;
            end
            if (capture) begin
                c_rs1_q   <= rs1_q;
                c_rs2_q   <= rs2_q;
                c_prod_q  <= core_prod;
                c_valid_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Directed plus randomized checks of mul_seq_ctrl against a plain-arithmetic
// model of the signed product and the single-entry cache.
module tb_mul_seq_ctrl;

    localparam int unsigned N = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic         op_high = 1'b0;
    logic [N-1:0] rs1 = '0;
    logic [N-1:0] rs2 = '0;
    logic         flush = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [N-1:0] result;
    logic         busy;

    int vectors = 0;
    int miscompares = 0;

    // Model of the cache: operands of the last completed (not flushed) miss.
    logic         m_valid = 1'b0;
    logic [N-1:0] m_a = '0;
    logic [N-1:0] m_b = '0;

    mul_seq_ctrl #(
        .N(N)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .op_high  (op_high),
        .rs1      (rs1),
        .rs2      (rs2),
        .flush    (flush),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result   (result),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [N-1:0] model_res(input logic [N-1:0] a, input logic [N-1:0] b,
                                                input logic hi);
        int p;
        logic [2*N-1:0] p2;
        p  = $signed(a) * $signed(b);
        p2 = p[2*N-1:0];
        return hi ? p2[2*N-1:N] : p2[N-1:0];
    endfunction

    // Called with inputs already driven, #1 after a negedge.
    task automatic wait_ready(input string tag);
        int n = 0;
        while (!in_ready && n < 60) begin
            @(negedge clk);
            #1;
            n++;
        end
        check(tag, in_ready, 1);
    endtask

    // Reset for cyc cycles (optionally with flush), then check idle outputs and holdoff length.
    task automatic do_reset(input int cyc, input logic with_flush);
        int n = 0;
        @(negedge clk);
        reset = 1'b1;
        flush = with_flush;
        in_valid = 1'b0;
        repeat (cyc - 1) @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        flush = 1'b0;
        #1;
        m_valid = 1'b0;
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_result", result, 0);
        check("rst_start", dut.core_start, 0);
        while (!in_ready && n < 40) begin
            n++;
            @(negedge clk);
            #1;
        end
        check("holdoff_cycles", n, 2 * N + 2);
    endtask

    task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic hi,
                         input int hold);
        logic         exp_hit;
        logic [N-1:0] exp_res;
        int           lat;
        int           starts;
        exp_hit = m_valid && (a == m_a) && (b == m_b);
        exp_res = model_res(a, b, hi);
        @(negedge clk);
        in_valid  = 1'b1;
        rs1       = a;
        rs2       = b;
        op_high   = hi;
        out_ready = 1'b0;
        #1;
        wait_ready("op_ready");
        @(negedge clk);
        in_valid = 1'b0;
        rs1      = N'($urandom);
        rs2      = N'($urandom);
        op_high  = 1'($urandom);
        #1;
        lat    = 1;
        starts = 0;
        while (!out_valid && lat < 40) begin
            if (dut.core_start) starts++;
            @(negedge clk);
            #1;
            lat++;
        end
        check("op_out_valid", out_valid, 1);
        if (exp_hit) begin
            check("hit_latency", lat, 1);
            check("hit_starts", starts, 0);
        end else begin
            check("miss_latency_gt1", lat > 1, 1);
            check("miss_starts", starts, 1);
        end
        check("op_result", result, exp_res);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            #1;
            check("hold_valid", out_valid, 1);
            check("hold_result", result, exp_res);
            check("hold_in_ready", in_ready, 0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        check("take_valid", out_valid, 1);
        check("take_result", result, exp_res);
        @(negedge clk);
        out_ready = 1'b0;
        #1;
        check("after_busy", busy, 0);
        check("after_valid", out_valid, 0);
        if (!exp_hit) begin
            m_valid = 1'b1;
            m_a     = a;
            m_b     = b;
        end
    endtask

    initial begin
        int  n;
        logic seen_done;
        logic ov_seen;

        do_reset(2, 1'b0);

        do_op(4'hA, 4'hD, 1'b0, 0);
        do_op(4'hA, 4'hD, 1'b1, 0);
        do_op(4'h7, 4'h8, 1'b1, 5);
        do_op(4'h8, 4'h8, 1'b1, 0);

        // Flush two cycles after the start pulse: drain until done, no response.
        @(negedge clk);
        in_valid = 1'b1;
        rs1 = 4'h5;
        rs2 = 4'h2;
        op_high = 1'b0;
        #1;
        wait_ready("drain_ready");
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("drain_start", dut.core_start, 1);
        @(negedge clk);
        #1;
        @(negedge clk);
        flush = 1'b1;
        #1;
        check("flush_in_ready", in_ready, 0);
        check("flush_busy", busy, 1);
        @(negedge clk);
        flush = 1'b0;
        #1;
        check("drain_busy", busy, 1);
        n = 0;
        seen_done = 1'b0;
        ov_seen = 1'b0;
        while (busy && n < 40) begin
            if (dut.core_done) seen_done = 1'b1;
            if (out_valid) ov_seen = 1'b1;
            @(negedge clk);
            #1;
            n++;
        end
        check("drain_idle", busy, 0);
        check("drain_saw_done", seen_done, 1);
        check("drain_no_valid", ov_seen, 0);

        do_op(4'h8, 4'h8, 1'b0, 0);
        do_op(4'h3, 4'h3, 1'b0, 0);

        // Flush while the response is offered: out_valid drops, cache survives.
        @(negedge clk);
        in_valid = 1'b1;
        rs1 = 4'h3;
        rs2 = 4'h3;
        op_high = 1'b0;
        #1;
        wait_ready("rflush_ready");
        @(negedge clk);
        in_valid = 1'b0;
        flush = 1'b1;
        #1;
        check("rflush_valid", out_valid, 0);
        @(negedge clk);
        flush = 1'b0;
        #1;
        check("rflush_busy", busy, 0);
        check("rflush_valid2", out_valid, 0);
        do_op(4'h3, 4'h3, 1'b1, 1);

        // Reset while waiting on the core, with flush also high.
        @(negedge clk);
        in_valid = 1'b1;
        rs1 = 4'h6;
        rs2 = 4'h5;
        op_high = 1'b0;
        #1;
        wait_ready("rwait_ready");
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("rwait_start", dut.core_start, 1);
        do_reset(1, 1'b1);
        do_op(4'h6, 4'h5, 1'b0, 0);
        do_op(4'h6, 4'h5, 1'b1, 0);

        for (int i = 0; i < 24; i++) begin
            logic [N-1:0] a;
            logic [N-1:0] b;
            if (m_valid && $urandom_range(0, 2) == 0) begin
                a = m_a;
                b = m_b;
            end else begin
                a = N'($urandom);
                b = N'($urandom);
            end
            do_op(a, b, 1'($urandom), int'($urandom_range(0, 2)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
